mem_arbiter: RTL and testbench

- Shares one single-port synchronous-read memory between the processor's instruction-fetch port (I) and load/store port (D).
- Sits between the processor datapath (pc/instruction path and data-memory path) and a unified RAM.
- Uses a req/ack handshake per requester and a 3-state FSM.
- D has priority; a streak counter prevents I starvation.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter_prio_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the I/D memory arbiter.
// Revision 1.0
`default_nettype none

package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } sel_t;

   localparam int MAX_D_STREAK_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: processor-side fetch (I) and load/store (D) handshake bundle.
// Revision 1.0
`default_nettype none

interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;

   logic          d_req;
   logic          d_we;
   logic [3:0]    d_be;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;

   // master = processor datapath, slave = arbiter
   modport master (
      output i_req, i_addr,
      input  i_ack, i_rdata,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_ack, d_rdata
   );

   modport slave (
      input  i_req, i_addr,
      output i_ack, i_rdata,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_ack, d_rdata
   );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_prio_pick.sv
// arb_prio_pick: D-priority pick with a forced I grant once the D streak limit is hit.
// Revision 1.0
`default_nettype none

module arb_prio_pick
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
   input  logic       i_req,
   input  logic       d_req,
   input  logic [3:0] streak,
   output logic       grant,
   output sel_t       winner
);

   logic force_i;

   always_comb begin
      force_i = i_req && (streak == 4'(MAX_D_STREAK));
      grant   = i_req || d_req;
      winner  = (force_i || !d_req) ? SEL_I : SEL_D;
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between fetch (I) and load/store (D) ports.
// Revision 1.0
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_if.slave    bus,
   output logic            mem_en,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [AW-3:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy
);

   state_t     state;
   sel_t       winner;
   logic [3:0] streak;
   logic       grant;
   sel_t       pick;

   arb_prio_pick #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_pick (
      .i_req  (bus.i_req),
      .d_req  (bus.d_req),
      .streak (streak),
      .grant  (grant),
      .winner (pick)
   );

   // Read data is only meaningful while the matching ack is high.
   assign bus.i_rdata = mem_rdata;
   assign bus.d_rdata = mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         winner    <= SEL_I;
         streak    <= 4'd0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  winner <= pick;
                  state  <= ACCESS;
                  busy   <= 1'b1;
                  mem_en <= 1'b1;
                  if (pick == SEL_D) begin
                     mem_we    <= bus.d_we;
                     mem_be    <= bus.d_we ? bus.d_be : 4'hF;
                     mem_addr  <= bus.d_addr[AW-1:2];
                     mem_wdata <= bus.d_wdata;
                     // Count only D grants that made a pending fetch wait.
                     if (!bus.i_req)
                        streak <= 4'd0;
                     else if (streak != 4'(MAX_D_STREAK))
                        streak <= streak + 4'd1;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_be    <= 4'hF;
                     mem_addr  <= bus.i_addr[AW-1:2];
                     mem_wdata <= '0;
                     streak    <= 4'd0;
                  end
               end
            end
            ACCESS: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               state  <= RESP;
               if (winner == SEL_I)
                  bus.i_ack <= 1'b1;
               else
                  bus.d_ack <= 1'b1;
            end
            RESP: begin
               bus.i_ack <= 1'b0;
               bus.d_ack <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               bus.i_ack <= 1'b0;
               bus.d_ack <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a small RAM model.
// Revision 1.0
`default_nettype none

module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [29:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic        is_d;
      logic        chk;
      logic [31:0] data;
   } resp_t;

   logic        clk;
   logic        rst;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   logic [31:0] ram [0:255];

   cmd_t  cmd_q[$];
   resp_t resp_q[$];

   int checks   = 0;
   int failures = 0;

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: read-first, data one cycle after mem_en
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= ram[mem_addr[7:0]];
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: memory commands and acks popped against queued expectations
   always @(negedge clk) begin
      if (rst) begin
         if (mem_en) begin
            if (cmd_q.size() == 0) begin
               check("unexpected_mem_cmd", 64'd1, 64'd0);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               check("mem_we", 64'(mem_we), 64'(c.we));
               check("mem_be", 64'(mem_be), 64'(c.be));
               check("mem_addr", 64'(mem_addr), 64'(c.addr));
               if (c.we) check("mem_wdata", 64'(mem_wdata), 64'(c.wdata));
            end
         end
         if (bus.i_ack || bus.d_ack) begin
            if (bus.i_ack && bus.d_ack) check("both_acks", 64'd1, 64'd0);
            if (resp_q.size() == 0) begin
               check("unexpected_ack", 64'd1, 64'd0);
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               check("ack_owner", 64'(bus.d_ack), 64'(r.is_d));
               if (r.chk)
                  check("rdata", 64'(r.is_d ? bus.d_rdata : bus.i_rdata), 64'(r.data));
            end
         end
      end
   end

   task automatic expect_txn(input bit is_d, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input bit chk);
      cmd_t  c;
      resp_t r;
      c.we    = is_d ? we : 1'b0;
      c.be    = (is_d && we) ? be : 4'hF;
      c.addr  = addr[31:2];
      c.wdata = wd;
      r.is_d  = is_d;
      r.chk   = chk;
      r.data  = rd;
      cmd_q.push_back(c);
      resp_q.push_back(r);
   endtask

   task automatic wait_ack(input bit is_d, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(is_d ? bus.d_ack : bus.i_ack) && cyc < 40);
   endtask

   // One transaction on one port; latency from req cycle to ack cycle must be 2
   task automatic single(input bit is_d, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input bit chk, input string name);
      int cyc;
      expect_txn(is_d, we, be, addr, wd, rd, chk);
      @(posedge clk); #1;
      if (is_d) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wd;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = addr;
      end
      wait_ack(is_d, cyc);
      check(name, 64'(cyc - 1), 64'd2);
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      bus.i_req = 1'b0;
   endtask

   initial begin
      int cyc;
      int nd;
      for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
      ram[8]      = 32'h1122_3344;
      mem_rdata   = '0;
      bus.i_req   = 1'b0; bus.i_addr = '0;
      bus.d_req   = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_acks", 64'({bus.i_ack, bus.d_ack}), 64'd0);
      check("rst_mem_be", 64'(mem_be), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_streak", 64'(dut.streak), 64'd0);
      rst = 1'b1;

      single(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h1000_0004, 1'b1, "i_fetch_latency");
      single(1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, "d_store_latency");
      single(1'b1, 1'b0, 4'b0011, 32'h20, 32'h0, 32'h1122_BEEF, 1'b1, "d_load_latency");

      // Simultaneous requests, streak 0: D first, I three cycles later
      expect_txn(1'b1, 1'b0, 4'hF, 32'h24, 32'h0, 32'h1000_0009, 1'b1);
      expect_txn(1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 32'h1000_000C, 1'b1);
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h24;
      bus.i_req = 1'b1; bus.i_addr = 32'h30;
      wait_ack(1'b1, cyc);
      check("simul_d_latency", 64'(cyc - 1), 64'd2);
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      cyc = 1;
      while (!bus.i_ack && cyc < 40) begin
         @(negedge clk);
         if (!bus.i_ack) cyc++;
      end
      check("simul_i_after_d", 64'(cyc), 64'd3);
      @(posedge clk); #1;
      bus.i_req = 1'b0;

      // Continuous D with a pending fetch: 4 D grants then a forced I grant
      for (int k = 0; k < 4; k++)
         expect_txn(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h1000_0010, 1'b1);
      expect_txn(1'b0, 1'b0, 4'h0, 32'h44, 32'h0, 32'h1000_0011, 1'b1);
      expect_txn(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h1000_0010, 1'b1);
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h40;
      bus.i_req = 1'b1; bus.i_addr = 32'h44;
      nd = 0; cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (bus.d_ack) nd++;
      end while (!bus.i_ack && cyc < 100);
      check("d_acks_before_forced_i", 64'(nd), 64'd4);
      @(posedge clk); #1;
      bus.i_req = 1'b0;
      @(negedge clk);
      check("streak_after_i", 64'(dut.streak), 64'd0);
      wait_ack(1'b1, cyc);
      check("d_resumes", 64'(cyc < 40), 64'd1);
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      check("streak_after_lone_d", 64'(dut.streak), 64'd0);

      // Reset during ACCESS abandons the fetch
      begin
         cmd_t c;
         c.we = 1'b0; c.be = 4'hF; c.addr = 30'h4; c.wdata = '0;
         cmd_q.push_back(c);
      end
      @(posedge clk); #1;
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!mem_en && cyc < 40);
      #1 rst = 1'b0;
      #1;
      check("rst_async_mem_en", 64'(mem_en), 64'd0);
      check("rst_async_busy", 64'(busy), 64'd0);
      bus.i_req = 1'b0;
      @(negedge clk);
      check("rst_state_idle", 64'(dut.state), 64'(IDLE));
      rst = 1'b1;
      repeat (4) @(negedge clk);
      single(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h1000_0004, 1'b1, "refetch_latency");

      // Quiet period
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle_busy_mem_en", 64'({busy, mem_en}), 64'd0);
      end
      check("idle_streak", 64'(dut.streak), 64'd0);

      repeat (3) @(negedge clk);
      check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
      check("resp_q_drained", 64'(resp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
